// File: rtl/comando_movimento_if.sv
// comando_movimento_if
//
// Bundles the command and motion signals of the comando_movimento sequencer.
//
// Signals:
//   start       command strobe from the top-level controller
//   dir_alvo    target heading (001 Norte, 010 Oeste, 011 Leste, 100 Sul)
//   passos      number of advances requested, 0..15
//   orientacao  current heading fed back from the orientation block
//   girar       turn request to the orientation block
//   avancar     advance request to the advance block
//   busy        sequencer is processing a command
//   done        one-cycle pulse, command completed
//   erro        one-cycle pulse, command aborted
//
// Modports:
//   master  the sequencer side; it initiates girar/avancar
//   slave   the surrounding controller and motion blocks
interface comando_movimento_if;

  logic       start;
  logic [2:0] dir_alvo;
  logic [3:0] passos;
  logic [2:0] orientacao;
  logic       girar;
  logic       avancar;
  logic       busy;
  logic       done;
  logic       erro;

  modport master (
    input  start,
    input  dir_alvo,
    input  passos,
    input  orientacao,
    output girar,
    output avancar,
    output busy,
    output done,
    output erro
  );

  modport slave (
    output start,
    output dir_alvo,
    output passos,
    output orientacao,
    input  girar,
    input  avancar,
    input  busy,
    input  done,
    input  erro
  );

endinterface

// File: rtl/comando_movimento.sv
// comando_movimento
//
// Command sequencer for the robot motion blocks. A command (target heading plus
// a step count) is latched in OCIOSO. The sequencer then issues girar pulses
// until the fed-back heading equals the target, and one avancar pulse per step,
// rechecking the heading before every step. A successful command ends with a
// one-cycle done pulse; an invalid heading, a turn that would exceed three
// rotations, or (optionally) a stuck turn ends with a one-cycle erro pulse.
//
// Parameters:
//   PULSO    cycles each girar/avancar pulse is held high, and length of the
//            low gap after each advance (>= 1)
//   TIMEOUT  cycles to wait for a heading change after a girar pulse; only
//            used when TIMEOUT_EN is defined
//
// Ports:
//   c1     clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    comando_movimento_if.master (start, dir_alvo, passos, orientacao in;
//          girar, avancar, busy, done, erro out)
//
// Build option:
//   TIMEOUT_EN  when defined, ESPERA_G gives up after TIMEOUT cycles without a
//               heading change and aborts with erro. When undefined, ESPERA_G
//               waits indefinitely and only reset leaves it.
//
// All outputs are registers loaded from the decoded next state, so they line
// up with the state register and drop to 0 as soon as reset is asserted.
module comando_movimento #(
  parameter int unsigned PULSO   = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                 c1,
  input logic                 reset,
  comando_movimento_if.master bus
);

  // The shared counter must hold PULSO-1 and TIMEOUT-1.
  localparam int unsigned CntMax = (TIMEOUT > PULSO) ? TIMEOUT : PULSO;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] PulsoLd = CntW'(PULSO - 1);
`ifdef TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLd = CntW'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    StOcioso,
    StCheca,
    StGira,
    StEsperaG,
    StAvanca,
    StPausa,
    StFim,
    StErro
  } state_e;

  state_e state_q, state_d;

  logic [2:0]      dir_q, dir_d;     // latched target heading
  logic [3:0]      resto_q, resto_d; // advances still to issue
  logic [1:0]      giros_q, giros_d; // turns issued for this command
  logic [2:0]      head_q, head_d;   // heading captured when a turn starts
  logic [CntW-1:0] cnt_q, cnt_d;     // pulse/gap/timeout counter

  logic girar_q, girar_d;
  logic avancar_q, avancar_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic erro_q, erro_d;

  logic dir_valida;
  logic alinhado;
  logic cnt_zero;

  // Only the four cardinal encodings 001..100 are legal headings.
  assign dir_valida = (bus.dir_alvo == 3'b001) || (bus.dir_alvo == 3'b010) ||
                      (bus.dir_alvo == 3'b011) || (bus.dir_alvo == 3'b100);
  assign alinhado   = (bus.orientacao == dir_q);
  assign cnt_zero   = (cnt_q == '0);

  //--------------------------------------------------------------------------
  // Next-state and datapath
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    resto_d = resto_q;
    giros_d = giros_q;
    head_d  = head_q;
    cnt_d   = cnt_zero ? cnt_q : (cnt_q - CntW'(1));

    unique case (state_q)
      StOcioso: begin
        if (bus.start) begin
          if (dir_valida) begin
            dir_d   = bus.dir_alvo;
            resto_d = bus.passos;
            giros_d = 2'd0;
            state_d = StCheca;
          end else begin
            state_d = StErro;
          end
        end
      end

      StCheca: begin
        if (alinhado) begin
          state_d = (resto_q == 4'd0) ? StFim : StAvanca;
        end else if (giros_q == 2'd3) begin
          // Three turns cover the full rotation; a fourth means the feedback
          // is not following the requests.
          state_d = StErro;
        end else begin
          head_d  = bus.orientacao;
          giros_d = giros_q + 2'd1;
          state_d = StGira;
        end
      end

      StGira: begin
        if (cnt_zero) begin
          state_d = StEsperaG;
        end
      end

      StEsperaG: begin
        if (bus.orientacao != head_q) begin
          state_d = StCheca;
        end
`ifdef TIMEOUT_EN
        else if (cnt_zero) begin
          state_d = StErro;
        end
`endif
      end

      StAvanca: begin
        if (cnt_zero) begin
          resto_d = resto_q - 4'd1;
          state_d = StPausa;
        end
      end

      StPausa: begin
        if (cnt_zero) begin
          state_d = StCheca;
        end
      end

      StFim: begin
        state_d = StOcioso;
      end

      StErro: begin
        state_d = StOcioso;
      end

      default: begin
        state_d = StOcioso;
      end
    endcase

    // The counter restarts on every state change.
    if (state_d != state_q) begin
`ifdef TIMEOUT_EN
      cnt_d = (state_d == StEsperaG) ? TimeoutLd : PulsoLd;
`else
      cnt_d = PulsoLd;
`endif
    end
  end

  //--------------------------------------------------------------------------
  // Output decode from the next state
  //--------------------------------------------------------------------------
  always_comb begin
    girar_d   = (state_d == StGira);
    avancar_d = (state_d == StAvanca);
    busy_d    = (state_d != StOcioso);
    done_d    = (state_d == StFim);
    erro_d    = (state_d == StErro);
  end

  //--------------------------------------------------------------------------
  // State and output registers
  //--------------------------------------------------------------------------
  always_ff @(posedge c1 or posedge reset) begin
    if (reset) begin
      state_q   <= StOcioso;
      dir_q     <= 3'b000;
      resto_q   <= 4'd0;
      giros_q   <= 2'd0;
      head_q    <= 3'b000;
      cnt_q     <= '0;
      girar_q   <= 1'b0;
      avancar_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      resto_q   <= resto_d;
      giros_q   <= giros_d;
      head_q    <= head_d;
      cnt_q     <= cnt_d;
      girar_q   <= girar_d;
      avancar_q <= avancar_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      erro_q    <= erro_d;
    end
  end

  assign bus.girar   = girar_q;
  assign bus.avancar = avancar_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.erro    = erro_q;

endmodule

// File: tb/tb_comando_movimento.sv
// tb_comando_movimento
//
// Directed bench for comando_movimento. A heading model rotates orientacao
// Norte->Oeste->Sul->Leste two cycles after each girar rising edge (unless
// frozen). A monitor counts girar/avancar pulses and checks their widths, the
// gap between advances and mutual exclusion. Each command pushes its expected
// outcome onto a scoreboard queue, which is popped when done or erro appears.
module tb_comando_movimento;

  localparam int unsigned PULSO   = 2;
  localparam int unsigned TIMEOUT = 16;

  logic c1    = 1'b0;
  logic reset = 1'b1;

  comando_movimento_if bus ();

  comando_movimento #(
    .PULSO  (PULSO),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .c1   (c1),
    .reset(reset),
    .bus  (bus)
  );

  always #5 c1 = ~c1;

  typedef struct {
    int ng;  // girar pulses expected
    int na;  // avancar pulses expected
    bit ok;  // 1: done expected, 0: erro expected
    int lat; // negedges from cycle k+1 to the done/erro cycle
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Heading model: orientacao = sequence[base_idx + rotations since set].
  int base_idx = 0;
  int rot_off  = 0;
  int rot_cnt  = 0;
  bit freeze   = 1'b0;
  int pend     = 0;

  function automatic logic [2:0] head_of(input int idx);
    case (idx & 3)
      0:       return 3'b001; // Norte
      1:       return 3'b010; // Oeste
      2:       return 3'b100; // Sul
      default: return 3'b011; // Leste
    endcase
  endfunction

  assign bus.orientacao = head_of(base_idx + rot_cnt - rot_off);

  // Monitor state
  int   n_girar   = 0;
  int   n_avancar = 0;
  int   width_err = 0;
  int   gap_err   = 0;
  int   both_err  = 0;
  int   g_run     = 0;
  int   a_run     = 0;
  int   gap_cnt   = 0;
  bit   gap_active = 1'b0;
  logic g_prev    = 1'b0;
  logic a_prev    = 1'b0;

  always @(negedge c1) begin
    if (bus.girar && !g_prev) begin
      pend = 2;
    end else if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0 && !freeze) rot_cnt = rot_cnt + 1;
    end

    if (bus.girar && bus.avancar) both_err = both_err + 1;

    if (bus.girar) begin
      if (!g_prev) n_girar = n_girar + 1;
      g_run = g_run + 1;
    end else begin
      if (g_prev && g_run != int'(PULSO)) width_err = width_err + 1;
      g_run = 0;
    end

    if (bus.avancar) begin
      if (!a_prev) begin
        n_avancar = n_avancar + 1;
        // Low time between advances: PAUSA plus the CHECA recheck.
        if (gap_active && gap_cnt != int'(PULSO) + 1) gap_err = gap_err + 1;
        gap_active = 1'b0;
      end
      a_run = a_run + 1;
    end else begin
      if (a_prev) begin
        if (a_run != int'(PULSO)) width_err = width_err + 1;
        gap_active = 1'b1;
        gap_cnt    = 0;
      end
      a_run = 0;
      if (gap_active) gap_cnt = gap_cnt + 1;
    end

    if (!bus.busy) gap_active = 1'b0;

    g_prev = bus.girar;
    a_prev = bus.avancar;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp)
    else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_heading(input int idx);
    base_idx = idx;
    rot_off  = rot_cnt;
  endtask

  // Issue one command and check its whole outcome against the scoreboard.
  task automatic run(input string tag, input logic [2:0] dir, input logic [3:0] np,
                     input int ng, input int na, input bit ok, input int lat);
    int   s_g, s_a, s_w, s_gp, s_b, n;
    exp_t e;
    @(negedge c1);
    s_g  = n_girar;
    s_a  = n_avancar;
    s_w  = width_err;
    s_gp = gap_err;
    s_b  = both_err;
    e.ng = ng;
    e.na = na;
    e.ok = ok;
    e.lat = lat;
    sb.push_back(e);
    bus.start    = 1'b1;
    bus.dir_alvo = dir;
    bus.passos   = np;
    @(negedge c1);
    // Command inputs change after the strobe; the latched copy must not.
    bus.start    = 1'b0;
    bus.dir_alvo = ~dir;
    bus.passos   = ~np;
    check({tag, ".busy_k1"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!(bus.done || bus.erro) && n < 400) begin
      @(negedge c1);
      n = n + 1;
    end
    e = sb.pop_front();
    check({tag, ".done"}, 32'(bus.done), 32'(e.ok));
    check({tag, ".erro"}, 32'(bus.erro), 32'(!e.ok));
    check({tag, ".busy_end"}, 32'(bus.busy), 32'd1);
    check({tag, ".latency"}, n, e.lat);
    check({tag, ".girar_pulses"}, n_girar - s_g, e.ng);
    check({tag, ".avancar_pulses"}, n_avancar - s_a, e.na);
    check({tag, ".pulse_width"}, width_err - s_w, 32'd0);
    check({tag, ".advance_gap"}, gap_err - s_gp, 32'd0);
    check({tag, ".exclusive"}, both_err - s_b, 32'd0);
    @(negedge c1);
    check({tag, ".busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, ".done_after"}, 32'(bus.done), 32'd0);
  endtask

  // Cycles from CHECA at k+1 to FIM: 4 per turn, 2*PULSO+1 per advance.
  function automatic int lat_ok(input int ng, input int na);
    return 4 * ng + (2 * int'(PULSO) + 1) * na + 1;
  endfunction

  initial begin
    int n;
    bus.start    = 1'b0;
    bus.dir_alvo = 3'b000;
    bus.passos   = 4'd0;
    set_heading(0);

    repeat (3) @(negedge c1);
    check("reset.girar", 32'(bus.girar), 32'd0);
    check("reset.avancar", 32'(bus.avancar), 32'd0);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.erro", 32'(bus.erro), 32'd0);
    reset = 1'b0;
    @(negedge c1);

    // Already aligned, no steps: done at k+2.
    set_heading(0);
    run("aligned", 3'b001, 4'd0, 0, 0, 1'b1, lat_ok(0, 0));

    // Norte -> Sul takes two turns, then two advances.
    set_heading(0);
    run("turn_adv", 3'b100, 4'd2, 2, 2, 1'b1, lat_ok(2, 2));

    // Norte -> Leste takes the maximum of three turns.
    set_heading(0);
    run("max_rot", 3'b011, 4'd1, 3, 1, 1'b1, lat_ok(3, 1));

    // Invalid headings abort at k+1 with no motion.
    run("inval_111", 3'b111, 4'd5, 0, 0, 1'b0, 0);
    run("inval_000", 3'b000, 4'd1, 0, 0, 1'b0, 0);
    run("inval_101", 3'b101, 4'd2, 0, 0, 1'b0, 0);

    // Heading is Leste after max_rot; a valid command still completes.
    run("after_inv", 3'b011, 4'd3, 0, 3, 1'b1, lat_ok(0, 3));

`ifdef TIMEOUT_EN
    // Frozen heading: one turn, then erro after TIMEOUT cycles in ESPERA_G.
    set_heading(0);
    freeze = 1'b1;
    run("timeout", 3'b010, 4'd3, 1, 0, 1'b0, 2 + int'(PULSO) + int'(TIMEOUT) - 1);
    freeze = 1'b0;
`endif

    // Reset while an advance is in progress.
    set_heading(1);
    @(negedge c1);
    bus.start    = 1'b1;
    bus.dir_alvo = 3'b010;
    bus.passos   = 4'd4;
    @(negedge c1);
    bus.start = 1'b0;
    n = 0;
    while (!bus.avancar && n < 50) begin
      @(negedge c1);
      n = n + 1;
    end
    check("rst_mid.saw_avancar", 32'(bus.avancar), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid.avancar", 32'(bus.avancar), 32'd0);
    check("rst_mid.busy", 32'(bus.busy), 32'd0);
    check("rst_mid.girar", 32'(bus.girar), 32'd0);
    @(negedge c1);
    reset = 1'b0;
    @(negedge c1);
    run("post_rst", 3'b010, 4'd1, 0, 1, 1'b1, lat_ok(0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
